bpsk_transmitter: RTL and testbench
===================================

// Module: bpsk_transmitter
// PURPOSE
//  Transmit-side counterpart of the BPSK receive chain. Accepts host bytes on an
//  11-bit UART frame (start, 8 data LSB-first, even parity, stop) and buffers them
//  in a small byte FIFO. Each byte goes out as a sync word plus 8 data bits,
//  BPSK-modulated onto a 4-sample digital carrier, as a signed sample stream for the DAC.
// PARAMETERS
//  DATA_WIDTH      8        width of signed output sample
//  AMPLITUDE       100      carrier peak value; must fit in signed DATA_WIDTH
//  BAUD_DIV        4        clk cycles per UART bit (>=2)
//  CYCLES_PER_BIT  4        carrier cycles per BPSK symbol; symbol = 4*CYCLES_PER_BIT samples
//  FIFO_DEPTH      4        byte FIFO entries (power of 2)
//  SYNC_BITS       4        length of sync word sent before each byte
//  SYNC_WORD       4'b1011  sync pattern, sent MSB first
// PORTS
//  clk         in   1           system clock; one output sample per cycle
//  rst_n       in   1           synchronous reset, active low
//  uart_rx     in   1           UART serial input, idles high
//  signal      out  DATA_WIDTH  signed modulated sample, registered
//  tx_active   out  1           high while a sync or data symbol is being emitted
//  parity_err  out  1           1-cycle pulse: received frame had bad parity, byte dropped
//  frame_err   out  1           1-cycle pulse: stop bit sampled 0, byte dropped
//  overflow    out  1           1-cycle pulse: good byte arrived with FIFO full, byte dropped
// BEHAVIOUR
//  Reset (rst_n=0 at a clk edge): signal=0, tx_active=0, all pulses 0, FIFO empty,
//   UART RX and modulator FSMs to IDLE. Reset mid-frame or mid-symbol aborts at once.
//  UART RX FSM: IDLE -> START -> BITS -> STOP -> IDLE.
//   IDLE: uart_rx=0 -> START, counter cleared.
//   START: at count BAUD_DIV/2, rx=1 -> IDLE (glitch); rx=0 -> BITS.
//   BITS: sample every BAUD_DIV cycles from mid-start; 8 data then parity, LSB first.
//   STOP: one BAUD_DIV later sample stop. Checks in priority order:
//    stop=0 -> frame_err; parity odd over data+parity -> parity_err;
//    FIFO full -> overflow; else push byte. Pulse/push on cycle after stop sample.
//   Always returns to IDLE after STOP; a new start bit is detected from next cycle.
//  FIFO: push and pop in same cycle allowed, also when full (pop frees the slot).
//  Modulator FSM: IDLE -> SYNC -> DATA -> (SYNC | IDLE).
//   IDLE: FIFO non-empty -> pop, latch byte, SYNC; first sync sample on the next edge.
//   SYNC: SYNC_BITS symbols of SYNC_WORD, MSB first. DATA: 8 symbols, byte MSB first.
//   After last DATA sample: FIFO non-empty -> pop, SYNC with no gap; else IDLE.
//  Symbol: sample index k=0..4*CYCLES_PER_BIT-1; carrier by k mod 4 = {0,+A,0,-A}.
//   Bit 1 -> carrier as is; bit 0 -> negated (180 deg). Negation exact, no overflow.
//  signal=0 and tx_active=0 in IDLE. tx_active=1 on every emitted sample.
//  UART RX and modulator run independently; host may stream while a byte transmits.
// TESTING
//  1 Reset: rst_n low 3 cycles, uart_rx=1 -> signal=0, tx_active=0, no pulses.
//  2 Byte 0x5A, even parity 0, stop 1 -> no error pulses; 12 symbols out:
//    sync 1,0,1,1 then 0,1,0,1,1,0,1,0; bit-1 symbol samples 0,100,0,-100,...;
//    tx_active high exactly 12*16=192 cycles.
//  3 Byte 0x5A, parity bit 1 -> parity_err 1 cycle; FIFO empty; signal stays 0.
//  4 Byte 0x01, stop bit 0 -> frame_err only (priority over parity).
//  5 Send 0x11,0x22 back to back -> two 192-cycle bursts, no idle cycle between.
//  6 Hold modulator mid-byte, send 5 bytes (1 popped + 4 buffered) -> 6th byte pulses
//    overflow; all 5 accepted bytes go out in order.
//  7 Glitch: uart_rx low 1 cycle -> no byte, no pulses.
//  8 rst_n low mid-data symbol -> signal=0 next cycle; FIFO cleared.

Source files
------------

// File: rtl/bpsk_transmitter_if.sv
// Host-facing signal bundle of the BPSK transmitter: serial UART input plus the
// modulated sample stream and status pulses.
interface bpsk_transmitter_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic                         uart_rx;
  logic signed [DATA_WIDTH-1:0] signal;
  logic                         tx_active;
  logic                         parity_err;
  logic                         frame_err;
  logic                         overflow;

  // Host / bench side: drives the serial line, observes the DAC stream.
  modport master (
    output uart_rx,
    input  signal,
    input  tx_active,
    input  parity_err,
    input  frame_err,
    input  overflow
  );

  // Transmitter side.
  modport slave (
    input  uart_rx,
    output signal,
    output tx_active,
    output parity_err,
    output frame_err,
    output overflow
  );
endinterface

// File: rtl/bpsk_transmitter.sv
// BPSK transmitter: UART byte receiver -> byte FIFO -> sync word + 8 data symbols,
// each symbol a 4-sample carrier repeated CYCLES_PER_BIT times, phase-flipped for a 0.
module bpsk_transmitter #(
  parameter int unsigned          DATA_WIDTH     = 8,
  parameter int                   AMPLITUDE      = 100,
  parameter int unsigned          BAUD_DIV       = 4,
  parameter int unsigned          CYCLES_PER_BIT = 4,
  parameter int unsigned          FIFO_DEPTH     = 4,
  parameter int unsigned          SYNC_BITS      = 4,
  parameter logic [SYNC_BITS-1:0] SYNC_WORD      = 4'b1011
) (
  input logic               clk,
  input logic               rst_n,
  bpsk_transmitter_if.slave bus
);

  localparam int unsigned CntW   = $clog2(BAUD_DIV);
  localparam int unsigned AddrW  = $clog2(FIFO_DEPTH);
  localparam int unsigned SymLen = 4 * CYCLES_PER_BIT;
  localparam int unsigned KW     = $clog2(SymLen);
  localparam int unsigned FrameW = SYNC_BITS + 8;
  localparam int unsigned SymW   = $clog2(FrameW);

  localparam logic [CntW-1:0] BaudLast  = CntW'(BAUD_DIV - 1);
  localparam logic [CntW-1:0] HalfLast  = CntW'(BAUD_DIV / 2 - 1);
  localparam logic [KW-1:0]   KLast     = KW'(SymLen - 1);
  localparam logic [SymW-1:0] SyncLast  = SymW'(SYNC_BITS - 1);
  localparam logic [SymW-1:0] FrameLast = SymW'(FrameW - 1);

  localparam logic signed [DATA_WIDTH-1:0] AmpPos = DATA_WIDTH'(AMPLITUDE);
  localparam logic signed [DATA_WIDTH-1:0] AmpNeg = DATA_WIDTH'(-AMPLITUDE);

  typedef enum logic [1:0] {RxIdle, RxStart, RxBits, RxStop} rx_state_e;
  typedef enum logic [1:0] {ModIdle, ModSync, ModData} mod_state_e;

  // ---------------------------------------------------------------------------
  // UART receiver
  // ---------------------------------------------------------------------------
  rx_state_e       rx_state_q, rx_state_d;
  logic            rx_meta_q, rx_sync_q;
  logic [CntW-1:0] rx_cnt_q, rx_cnt_d;
  logic [3:0]      rx_bit_q, rx_bit_d;
  logic [8:0]      rx_shift_q, rx_shift_d;  // {parity, data[7:0]} once complete
  logic            stop_sample;

  logic parity_err_q, frame_err_q, overflow_q;
  logic frame_bad, par_bad, ovf_bad, push;

  logic            fifo_empty, fifo_full;
  logic [7:0]      fifo_rdata;
  logic            mod_pop;

  // Next-state of the receiver; all sampling happens in the synchronised domain.
  always_comb begin
    rx_state_d  = rx_state_q;
    rx_cnt_d    = rx_cnt_q + CntW'(1);
    rx_bit_d    = rx_bit_q;
    rx_shift_d  = rx_shift_q;
    stop_sample = 1'b0;
    unique case (rx_state_q)
      RxIdle: begin
        rx_cnt_d = '0;
        if (!rx_sync_q) rx_state_d = RxStart;
      end
      RxStart: begin
        // Mid start bit: a high line here was only a glitch.
        if (rx_cnt_q == HalfLast) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = rx_sync_q ? RxIdle : RxBits;
        end
      end
      RxBits: begin
        if (rx_cnt_q == BaudLast) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_sync_q, rx_shift_q[8:1]};
          if (rx_bit_q == 4'd8) rx_state_d = RxStop;
          else                  rx_bit_d   = rx_bit_q + 4'd1;
        end
      end
      RxStop: begin
        if (rx_cnt_q == BaudLast) begin
          rx_cnt_d    = '0;
          stop_sample = 1'b1;
          rx_state_d  = RxIdle;
        end
      end
      default: rx_state_d = RxIdle;
    endcase
  end

  // Error checks in priority order: framing, parity, then FIFO space.
  // A pop in the same cycle frees a slot, so a full FIFO can still accept.
  always_comb begin
    frame_bad = stop_sample & ~rx_sync_q;
    par_bad   = stop_sample & rx_sync_q & (^rx_shift_q);
    ovf_bad   = stop_sample & rx_sync_q & ~(^rx_shift_q) & fifo_full & ~mod_pop;
    push      = stop_sample & rx_sync_q & ~(^rx_shift_q) & ~(fifo_full & ~mod_pop);
  end

  // Receiver state, input synchroniser and registered status pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_state_q   <= RxIdle;
      rx_meta_q    <= 1'b1;
      rx_sync_q    <= 1'b1;
      rx_cnt_q     <= '0;
      rx_bit_q     <= '0;
      rx_shift_q   <= '0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      rx_state_q   <= rx_state_d;
      rx_meta_q    <= bus.uart_rx;
      rx_sync_q    <= rx_meta_q;
      rx_cnt_q     <= rx_cnt_d;
      rx_bit_q     <= rx_bit_d;
      rx_shift_q   <= rx_shift_d;
      parity_err_q <= par_bad;
      frame_err_q  <= frame_bad;
      overflow_q   <= ovf_bad;
    end
  end

  // ---------------------------------------------------------------------------
  // Byte FIFO (extra pointer bit distinguishes full from empty)
  // ---------------------------------------------------------------------------
  logic [7:0]     fifo_mem [FIFO_DEPTH];
  logic [AddrW:0] wr_ptr_q, rd_ptr_q;

  always_comb begin
    fifo_empty = (wr_ptr_q == rd_ptr_q);
    fifo_full  = (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]) &&
                 (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);
    fifo_rdata = fifo_mem[rd_ptr_q[AddrW-1:0]];
  end

  // Storage array; contents are don't-care while the pointers say empty.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q[AddrW-1:0]] <= rx_shift_q[7:0];
  end

  // FIFO pointers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push)    wr_ptr_q <= wr_ptr_q + (AddrW+1)'(1);
      if (mod_pop) rd_ptr_q <= rd_ptr_q + (AddrW+1)'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Modulator
  // ---------------------------------------------------------------------------
  mod_state_e                   mod_state_q, mod_state_d;
  logic [KW-1:0]                k_q, k_d;
  logic [SymW-1:0]              sym_q, sym_d;
  logic [FrameW-1:0]            frame_q, frame_d;  // sync word + byte, sent MSB first
  logic                         cur_bit;
  logic signed [DATA_WIDTH-1:0] sample;
  logic signed [DATA_WIDTH-1:0] signal_q;
  logic                         tx_active_q;

  // Next-state of the modulator; a byte waiting at the end of a frame chains with no gap.
  always_comb begin
    mod_state_d = mod_state_q;
    k_d         = k_q;
    sym_d       = sym_q;
    frame_d     = frame_q;
    mod_pop     = 1'b0;
    unique case (mod_state_q)
      ModIdle: begin
        if (!fifo_empty) begin
          mod_pop     = 1'b1;
          frame_d     = {SYNC_WORD, fifo_rdata};
          k_d         = '0;
          sym_d       = '0;
          mod_state_d = ModSync;
        end
      end
      ModSync, ModData: begin
        k_d = k_q + KW'(1);
        if (k_q == KLast) begin
          k_d     = '0;
          frame_d = {frame_q[FrameW-2:0], 1'b0};
          sym_d   = sym_q + SymW'(1);
          if (sym_q == SyncLast) begin
            mod_state_d = ModData;
          end else if (sym_q == FrameLast) begin
            if (!fifo_empty) begin
              mod_pop     = 1'b1;
              frame_d     = {SYNC_WORD, fifo_rdata};
              sym_d       = '0;
              mod_state_d = ModSync;
            end else begin
              mod_state_d = ModIdle;
            end
          end
        end
      end
      default: mod_state_d = ModIdle;
    endcase
  end

  // Carrier lookup {0,+A,0,-A}; a 0 bit takes the opposite phase.
  always_comb begin
    cur_bit = frame_q[FrameW-1];
    case (k_q[1:0])
      2'd1:    sample = cur_bit ? AmpPos : AmpNeg;
      2'd3:    sample = cur_bit ? AmpNeg : AmpPos;
      default: sample = '0;
    endcase
  end

  // Modulator state and registered DAC output.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mod_state_q <= ModIdle;
      k_q         <= '0;
      sym_q       <= '0;
      frame_q     <= '0;
      signal_q    <= '0;
      tx_active_q <= 1'b0;
    end else begin
      mod_state_q <= mod_state_d;
      k_q         <= k_d;
      sym_q       <= sym_d;
      frame_q     <= frame_d;
      signal_q    <= (mod_state_q == ModIdle) ? '0 : sample;
      tx_active_q <= (mod_state_q != ModIdle);
    end
  end

  assign bus.signal     = signal_q;
  assign bus.tx_active  = tx_active_q;
  assign bus.parity_err = parity_err_q;
  assign bus.frame_err  = frame_err_q;
  assign bus.overflow   = overflow_q;

endmodule

// File: tb/tb_bpsk_transmitter.sv
// Scoreboard bench for bpsk_transmitter. Stimulus pushes expected samples, burst
// lengths and status pulses; a negedge monitor pops and compares.
// The UART runs at BAUD_DIV=2 so the host can queue more bytes than one
// 192-sample transmission takes, which is needed to reach FIFO overflow.
module tb_bpsk_transmitter;
  localparam int BD  = 2;
  localparam int AMP = 100;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bpsk_transmitter_if #(.DATA_WIDTH(8)) bus ();

  bpsk_transmitter #(
    .DATA_WIDTH    (8),
    .AMPLITUDE     (AMP),
    .BAUD_DIV      (BD),
    .CYCLES_PER_BIT(4),
    .FIFO_DEPTH    (4),
    .SYNC_BITS     (4),
    .SYNC_WORD     (4'b1011)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int errors = 0;
  int checks = 0;

  logic signed [7:0] sample_q[$];
  int                burst_q[$];
  logic [2:0]        pulse_q[$];  // {overflow, frame_err, parity_err}
  int                run_len = 0;
  bit                discard_burst = 1'b0;

  function automatic void check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic logic signed [7:0] exp_sample(input logic b, input int k);
    case (k % 4)
      1:       return b ? 8'sd100 : -8'sd100;
      3:       return b ? -8'sd100 : 8'sd100;
      default: return 8'sd0;
    endcase
  endfunction

  // Expected stream for one byte: sync 1011 then data MSB first, 16 samples per bit.
  task automatic expect_byte(input logic [7:0] d);
    logic [11:0] f;
    f = {4'b1011, d};
    for (int s = 11; s >= 0; s--)
      for (int k = 0; k < 16; k++) sample_q.push_back(exp_sample(f[s], k));
  endtask

  task automatic bit_out(input logic b);
    bus.uart_rx = b;
    repeat (BD) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stp);
    bit_out(1'b0);
    for (int i = 0; i < 8; i++) bit_out(d[i]);
    bit_out(par);
    bit_out(stp);
    bus.uart_rx = 1'b1;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (!bus.tx_active && sample_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL wait_idle: timed out with %0d samples pending", sample_q.size());
    end
    repeat (10) @(negedge clk);
  endtask

  // Monitor: samples while tx_active, zero while idle, burst lengths, pulses.
  always @(negedge clk) begin
    logic [2:0] code;
    if (bus.tx_active) begin
      run_len++;
      if (sample_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sample: got %0d, expected no transmission", int'(bus.signal));
      end else begin
        check("sample", int'(bus.signal), int'(sample_q.pop_front()));
      end
    end else begin
      check("idle_signal", int'(bus.signal), 0);
      if (run_len > 0) begin
        if (discard_burst) discard_burst = 1'b0;
        else if (burst_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL burst_len: got %0d, expected no burst", run_len);
        end else check("burst_len", run_len, burst_q.pop_front());
        run_len = 0;
      end
    end
    code = {bus.overflow, bus.frame_err, bus.parity_err};
    if (code != 3'b000) begin
      if (pulse_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pulse: got %b, expected none", code);
      end else check("pulse", int'(code), int'(pulse_q.pop_front()));
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] burst6 [6];
    int         seen;
    burst6 = '{8'h3C, 8'hC3, 8'h0F, 8'hF0, 8'h81, 8'h7E};

    // 1: reset
    bus.uart_rx = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_signal", int'(bus.signal), 0);
    check("reset_tx_active", int'(bus.tx_active), 0);
    check("reset_pulses", int'({bus.overflow, bus.frame_err, bus.parity_err}), 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // 2: single good byte
    expect_byte(8'h5A);
    burst_q.push_back(192);
    send_frame(8'h5A, ^8'h5A, 1'b1);
    wait_idle();

    // 3: bad parity
    pulse_q.push_back(3'b001);
    send_frame(8'h5A, ~(^8'h5A), 1'b1);
    repeat (40) @(negedge clk);

    // 4: bad stop with bad parity too: framing error wins
    pulse_q.push_back(3'b010);
    send_frame(8'h01, 1'b0, 1'b0);
    repeat (40) @(negedge clk);

    // 5: back-to-back bytes form one continuous burst
    expect_byte(8'h11);
    expect_byte(8'h22);
    burst_q.push_back(384);
    send_frame(8'h11, ^8'h11, 1'b1);
    send_frame(8'h22, ^8'h22, 1'b1);
    wait_idle();

    // 6: one byte popped, four buffered, sixth overflows
    for (int i = 0; i < 5; i++) expect_byte(burst6[i]);
    burst_q.push_back(5 * 192);
    pulse_q.push_back(3'b100);
    for (int i = 0; i < 6; i++) send_frame(burst6[i], ^burst6[i], 1'b1);
    wait_idle();

    // 7: one-cycle glitch on the line
    bus.uart_rx = 1'b0;
    @(negedge clk);
    bus.uart_rx = 1'b1;
    repeat (60) @(negedge clk);

    // 8: reset in the middle of data symbols with a second byte buffered
    expect_byte(8'h96);
    expect_byte(8'h69);
    send_frame(8'h96, ^8'h96, 1'b1);
    send_frame(8'h69, ^8'h69, 1'b1);
    seen = 0;
    for (int i = 0; i < 1000 && run_len < 100; i++) @(negedge clk);
    check("reset_mid_reached", int'(run_len >= 100), 1);
    discard_burst = 1'b1;
    rst_n = 1'b0;
    @(negedge clk);
    check("reset_mid_signal", int'(bus.signal), 0);
    check("reset_mid_tx_active", int'(bus.tx_active), 0);
    sample_q.delete();
    rst_n = 1'b1;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (bus.tx_active) seen++;
    end
    check("fifo_cleared", seen, 0);

    check("samples_left", sample_q.size(), 0);
    check("bursts_left", burst_q.size(), 0);
    check("pulses_left", pulse_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
